// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
//   XLEN        data width
//   REG_ADDR_W  register address width
//   NUM_REGS    number of architectural registers
//   wb_entry_t  queued writeback: live flag, destination, data
package regfile_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // One-hot decode of a register address.
    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] a);
        return NUM_REGS'(1) << a;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular queue of pending port-B writebacks.
//   clk, reset_n  clock, async active-low reset
//   push, entry   enqueue request (ignored when full)
//   pop           dequeue request (ignored when empty)
//   kill, kill_addr  clear the live flag of every stored entry targeting kill_addr
//   head          entry at the read pointer
//   count, full   occupancy from registered state
//   live_mask     OR of decoded addresses over live entries
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  wb_entry_t                    entry,
    input  logic                         pop,
    input  logic                         kill,
    input  logic [REG_ADDR_W-1:0]        kill_addr,
    output wb_entry_t                    head,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic [NUM_REGS-1:0]          live_mask
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy. Later assignments win: a popped slot is
    // cleared, and a freshly pushed entry stays live even if its address is killed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (kill) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (mem[i].live && (mem[i].addr == kill_addr)) begin
                        mem[i].live <= 1'b0;
                    end
                end
            end
            if (pop_ok) begin
                mem[rd_ptr].live <= 1'b0;
                rd_ptr           <= rd_ptr + PTR_W'(1);
            end
            if (push_ok) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Unoccupied slots always have live=0, so scanning every slot is safe.
    always_comb begin
        live_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (mem[i].live) begin
                live_mask = live_mask | addr_onehot(mem[i].addr);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single owner of the register-file write port; merges in-order writeback (A)
// with queued multi-cycle results (B), which drain only when A is idle.
//   clk, reset_n            clock, async active-low reset
//   a_we/a_addr/a_data      port A writeback (never stalled)
//   b_valid/b_ready/b_addr/b_data  port B result handshake
//   we3/a3/wd3              registered regfile write port
//   busy_mask               registers with live queued writes
// Optional macro REGFILE_WB_BYPASS_EN adds rs1/rs2 forwarding of the
// write happening at the next edge (rsN_addr in, rsN_fwd_valid/data out).
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_we,
    input  logic [REG_ADDR_W-1:0] a_addr,
    input  logic [XLEN-1:0]       a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_addr,
    input  logic [XLEN-1:0]       b_data,
    output logic                  we3,
    output logic [REG_ADDR_W-1:0] a3,
    output logic [XLEN-1:0]       wd3,
    output logic [NUM_REGS-1:0]   busy_mask
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_fwd_valid,
    output logic                  rs2_fwd_valid,
    output logic [XLEN-1:0]       rs1_fwd_data,
    output logic [XLEN-1:0]       rs2_fwd_data
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             a_valid;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;
    wb_entry_t        head;
    wb_entry_t        push_entry;

    assign a_valid    = a_we && (a_addr != '0);
    assign b_ready    = !full;
    assign empty      = (count == '0);
    // r0 results complete the handshake but are never queued.
    assign push       = b_valid && b_ready && (b_addr != '0);
    assign pop        = !a_valid && !empty;
    assign push_entry = '{live: 1'b1, addr: b_addr, data: b_data};

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .entry     (push_entry),
        .pop       (pop),
        .kill      (a_valid),
        .kill_addr (a_addr),
        .head      (head),
        .count     (count),
        .full      (full),
        .live_mask (busy_mask)
    );

    // Write-port selection: A first, then a live head; a killed head pops as a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we3 <= 1'b0;
            a3  <= '0;
            wd3 <= '0;
        end else if (a_valid) begin
            we3 <= 1'b1;
            a3  <= a_addr;
            wd3 <= a_data;
        end else if (pop && head.live) begin
            we3 <= 1'b1;
            a3  <= head.addr;
            wd3 <= head.data;
        end else begin
            we3 <= 1'b0;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // The regfile's combinational read misses the value being written this edge.
    assign rs1_fwd_valid = we3 && (a3 != '0) && (rs1_addr == a3);
    assign rs2_fwd_valid = we3 && (a3 != '0) && (rs2_addr == a3);
    assign rs1_fwd_data  = wd3;
    assign rs2_fwd_data  = wd3;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        a_we;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] busy_mask;
`ifdef REGFILE_WB_BYPASS_EN
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_fwd_valid;
    logic        rs2_fwd_valid;
    logic [31:0] rs1_fwd_data;
    logic [31:0] rs2_fwd_data;
`endif

    int checks;
    int errors;

    regfile_wb_arbiter #(
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3),
        .busy_mask (busy_mask)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_fwd_valid (rs1_fwd_valid),
        .rs2_fwd_valid (rs2_fwd_valid),
        .rs1_fwd_data  (rs1_fwd_data),
        .rs2_fwd_data  (rs2_fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending B writes in arrival order, plus expected write port.
    typedef struct {
        bit          live;
        logic [4:0]  addr;
        logic [31:0] data;
    } m_ent_t;

    m_ent_t      q[$];
    logic        exp_we3;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd3;

    function automatic logic [31:0] exp_mask();
        logic [31:0] m;
        m = '0;
        foreach (q[i]) if (q[i].live) m[q[i].addr] = 1'b1;
        return m;
    endfunction

    function automatic logic exp_ready();
        return q.size() < DEPTH;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_we3 = 1'b0;
        exp_a3  = '0;
        exp_wd3 = '0;
    endtask

    // Drive one cycle of inputs, advance the model, return #1 after the edge.
    task automatic apply(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        bit     acc;
        m_ent_t h;
        a_we = aw; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        acc = bv && (q.size() < DEPTH);
        if (aw && aa != 0) begin
            exp_we3 = 1'b1; exp_a3 = aa; exp_wd3 = ad;
            foreach (q[i]) if (q[i].live && q[i].addr == aa) q[i].live = 1'b0;
        end else if (q.size() > 0) begin
            h = q.pop_front();
            if (h.live) begin
                exp_we3 = 1'b1; exp_a3 = h.addr; exp_wd3 = h.data;
            end else begin
                exp_we3 = 1'b0;
            end
        end else begin
            exp_we3 = 1'b0;
        end
        if (acc && ba != 0) q.push_back('{live: 1'b1, addr: ba, data: bd});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        a_we = 0; a_addr = 0; a_data = 0; b_valid = 0; b_addr = 0; b_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL por_we3 got %b want 0", we3); end
        checks++; if (a3 !== 5'd0 || wd3 !== 32'd0) begin errors++; $display("FAIL por_a3_wd3 got %0d/%h want 0/0", a3, wd3); end
        checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL por_mask got %h want 0", busy_mask); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL por_ready got %b want 1", b_ready); end
        reset_n = 1'b1;
    endtask

    task automatic test_single_write();
        apply(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        checks++; if (we3 !== 1'b1 || a3 !== 5'd5 || wd3 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_write got we3=%b a3=%0d wd3=%h want 1/5/deadbeef", we3, a3, wd3); end
        apply(0, 0, 0, 0, 0, 0);
        checks++; if (we3 !== 1'b0 || a3 !== 5'd5) begin
            errors++; $display("FAIL single_idle got we3=%b a3=%0d want 0/5", we3, a3); end
    endtask

    task automatic test_fill_drain();
        logic [4:0] regs [4];
        regs[0] = 5'd7; regs[1] = 5'd8; regs[2] = 5'd9; regs[3] = 5'd11;
        for (int i = 0; i < 4; i++) begin
            apply(1, 5'd20, 32'(i), 1, regs[i], 32'h100 + 32'(i));
            checks++; if (b_ready !== (i < 3)) begin
                errors++; $display("FAIL fill_ready[%0d] got %b want %b", i, b_ready, (i < 3)); end
        end
        checks++; if (busy_mask !== 32'h0B80) begin errors++; $display("FAIL fill_mask got %h want 00000b80", busy_mask); end
        // Offer a fifth result while full: must be refused.
        apply(1, 5'd20, 32'h55, 1, 5'd12, 32'h999);
        checks++; if (busy_mask !== 32'h0B80) begin errors++; $display("FAIL full_refuse got %h want 00000b80", busy_mask); end
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 0, 0, 0);
            checks++; if (we3 !== 1'b1 || a3 !== regs[i] || wd3 !== 32'h100 + 32'(i)) begin
                errors++; $display("FAIL drain[%0d] got we3=%b a3=%0d wd3=%h want 1/%0d/%h",
                                   i, we3, a3, wd3, regs[i], 32'h100 + 32'(i)); end
        end
        checks++; if (busy_mask !== 32'd0 || b_ready !== 1'b1) begin
            errors++; $display("FAIL drained got mask=%h ready=%b want 0/1", busy_mask, b_ready); end
    endtask

    task automatic test_zero_addr();
        apply(1, 5'd0, 32'h1234, 1, 5'd0, 32'h5678);
        checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL zero_a_we3 got %b want 0", we3); end
        checks++; if (busy_mask !== 32'd0 || b_ready !== 1'b1) begin
            errors++; $display("FAIL zero_b got mask=%h ready=%b want 0/1", busy_mask, b_ready); end
        apply(0, 0, 0, 0, 0, 0);
        checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL zero_b_nowrite got %b want 0", we3); end
    endtask

    task automatic test_kill();
        apply(1, 5'd1, 32'hA, 1, 5'd10, 32'd1);
        checks++; if (busy_mask !== 32'h400) begin errors++; $display("FAIL kill_queued got %h want 00000400", busy_mask); end
        apply(1, 5'd10, 32'd2, 0, 0, 0);
        checks++; if (we3 !== 1'b1 || a3 !== 5'd10 || wd3 !== 32'd2) begin
            errors++; $display("FAIL kill_awrite got we3=%b a3=%0d wd3=%h want 1/10/2", we3, a3, wd3); end
        checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL kill_mask got %h want 0", busy_mask); end
        apply(0, 0, 0, 0, 0, 0);
        checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL kill_bubble got we3=%b want 0", we3); end
        // Same-cycle B push to the register A writes stays live.
        apply(1, 5'd6, 32'd3, 1, 5'd6, 32'd4);
        apply(0, 0, 0, 0, 0, 0);
        checks++; if (we3 !== 1'b1 || a3 !== 5'd6 || wd3 !== 32'd4) begin
            errors++; $display("FAIL same_cycle_b got we3=%b a3=%0d wd3=%h want 1/6/4", we3, a3, wd3); end
    endtask

    task automatic test_mid_reset();
        apply(1, 5'd20, 32'h1, 1, 5'd3, 32'h33);
        apply(1, 5'd21, 32'h2, 1, 5'd4, 32'h44);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++; if (we3 !== 1'b0 || busy_mask !== 32'd0 || b_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset got we3=%b mask=%h ready=%b want 0/0/1", we3, busy_mask, b_ready); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply(0, 0, 0, 0, 0, 0);
        checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL post_reset_drain got %b want 0", we3); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom);
            checks++; if (we3 !== exp_we3) begin errors++; $display("FAIL rnd_we3[%0d] got %b want %b", n, we3, exp_we3); end
            checks++; if (we3 && (a3 !== exp_a3 || wd3 !== exp_wd3)) begin
                errors++; $display("FAIL rnd_data[%0d] got %0d/%h want %0d/%h", n, a3, wd3, exp_a3, exp_wd3); end
            checks++; if (busy_mask !== exp_mask()) begin
                errors++; $display("FAIL rnd_mask[%0d] got %h want %h", n, busy_mask, exp_mask()); end
            checks++; if (b_ready !== exp_ready()) begin
                errors++; $display("FAIL rnd_ready[%0d] got %b want %b", n, b_ready, exp_ready()); end
        end
    endtask

`ifdef REGFILE_WB_BYPASS_EN
    task automatic test_bypass();
        apply(1, 5'd4, 32'd9, 0, 0, 0);
        rs1_addr = 5'd4;
        rs2_addr = 5'd0;
        #1;
        checks++; if (rs1_fwd_valid !== 1'b1 || rs1_fwd_data !== 32'd9) begin
            errors++; $display("FAIL bypass_rs1 got %b/%h want 1/9", rs1_fwd_valid, rs1_fwd_data); end
        checks++; if (rs2_fwd_valid !== 1'b0) begin
            errors++; $display("FAIL bypass_rs2 got %b want 0", rs2_fwd_valid); end
        rs1_addr = 5'd0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
`ifdef REGFILE_WB_BYPASS_EN
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
`endif
        test_reset();
        test_single_write();
        test_fill_drain();
        test_zero_addr();
        test_kill();
        test_mid_reset();
        test_random();
`ifdef REGFILE_WB_BYPASS_EN
        test_bypass();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
